dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory behind the MIPS core.
- Adds byte, halfword and word access with sign or zero extension, and configurable wait states with a stall handshake to the core.
- Adds one memory-mapped output register and fault detection for misaligned or out-of-range accesses.
- Sits between the mips datapath and the on-chip data RAM, in place of the direct dmem hookup.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the RAM array; power of two, 4..4096.
- WAIT_STATES, 1, extra cycles an access takes before completing; 0..15.
- MMIO_ADDR, 32'h0000_FFFC, word-aligned byte address of the memory-mapped output register.
- INIT_FILE, "", optional $readmemh image loaded at elaboration; empty means no load.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request; the core holds every req_* input stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  extended load result; valid only in the completion cycle.
- stall  out  1  combinational; high while an accepted request is still pending.
- fault  out  1  one-cycle pulse for a misaligned, illegal-size or out-of-range access.
- mmio_out  out  32  current value of the memory-mapped output register.

Behaviour:
- Reset: the FSM goes to IDLE, the wait counter clears to 0, mmio_out=0, fault=0, rdata=0. RAM contents are not cleared.
- Reset mid-access: the pending access is aborted. No write is committed and there is no completion.
- FSM states: IDLE, WAIT, DONE.
- IDLE with req_valid=1 and a legal request:
  - WAIT_STATES=0: complete in the same cycle. stall=0, a store commits at this edge, rdata is valid this cycle.
  - WAIT_STATES>0: stall=1, load the counter with WAIT_STATES-1 and go to WAIT.
- WAIT: stall=1. Decrement the counter; at 0 go to DONE.
- DONE: stall=0, rdata valid, a store commits at this edge. Return to IDLE.
- Latency: a request seen in cycle N completes in cycle N+WAIT_STATES.
- A new request may start in the cycle after DONE; there is no back-to-back overlap.
- Legality checks, evaluated in IDLE when req_valid=1:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal size: req_size=11.
  - Out of range: word index addr>>2 ≥ DEPTH_WORDS and addr != MMIO_ADDR.
  - Any of these: fault=1 for exactly one cycle, stall=0, no write, rdata=0, FSM stays in IDLE. No wait states are consumed.
- Store lane mapping:
  - byte: req_wdata[7:0] goes to lane addr[1:0].
  - half: req_wdata[15:0] goes to lanes {addr[1],1'b1 : addr[1],1'b0}.
  - word: all four lanes.
  - Unselected lanes are unchanged.
- Load: select the lane or lanes using the same mapping, then sign- or zero-extend to 32 bits according to req_signed. Word loads ignore req_signed.
- MMIO_ADDR, word accesses:
  - Store: updates mmio_out at the completion edge.
  - Load: returns mmio_out.
- MMIO_ADDR, byte and half accesses: store updates only the addressed lanes of the register; load extracts and extends as for RAM.
- MMIO_ADDR never aliases the RAM; the RAM word at the same index is untouched.
- Index width: $clog2(DEPTH_WORDS). Upper address bits must be zero for a RAM hit.
- req_valid falling while stall=1 is a protocol violation; the controller still completes the access.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state typedef;
  - function lane_mask(size, addr[1:0]) returning a 4-bit strobe.
- One sub-module, dmem_lane_ram:
  - DEPTH_WORDS x 32 array with 4-bit byte write strobe;
  - asynchronous read, synchronous write;
  - INIT_FILE support.
- The extraction/extension logic and the FSM stay in dmem_ctrl.

Test Plan:
- Aligned word store 0x12345678 to 0x10, then word load from 0x10 (WAIT_STATES=1) -> stall high for 1 cycle per access, rdata=0x12345678 in the second cycle of the load.
- Byte store 0x80 to 0x13 over 0x12345678, then signed byte load from 0x13 -> RAM word 0x80345678, rdata=0xFFFFFF80; unsigned load -> 0x00000080.
- Halfword store 0xBEEF to 0x22, signed half load from 0x22 -> 0xFFFFBEEF; word load from 0x20 -> [31:16]=0xBEEF, [15:0] unchanged.
- Word store to 0x0002; half load from 0x0001; req_size=11; word access at 0x400 with DEPTH_WORDS=64 -> each gives fault=1 for one cycle, stall=0, RAM unchanged.
- Word store 0xA5A5A5A5 to MMIO_ADDR -> mmio_out=0xA5A5A5A5 at the completion edge; RAM word at index 0x3FFF unchanged; word load from MMIO_ADDR returns 0xA5A5A5A5.
- WAIT_STATES=3: assert reset in the second stalled cycle of a store -> FSM returns to IDLE, store not committed, stall=0 the next cycle, mmio_out=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, request struct and byte-strobe helper for the data memory controller.
package mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} dm_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [1:0] a);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << a;
      SZ_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Word-organised data RAM with per-byte write strobes, async read, sync write.
module dmem_lane_ram
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 64,
  parameter string INIT_FILE   = "",
  parameter int    AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [NUM_LANES-1:0] be,
  input  logic [AW-1:0]        waddr,
  input  logic [31:0]          wdata,
  input  logic [AW-1:0]        raddr,
  output logic [31:0]          rdata
);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) mem[waddr][l] <= wdata[l*LANE_W +: LANE_W];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: sized/extended loads and stores, wait states with stall,
// one memory-mapped output register and fault detection.
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_ADDR   = 32'h0000_FFFC,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic [31:0] mmio_out
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 4;
  localparam bit ZERO_WS = (WAIT_STATES == 0);

  dm_state_e state;
  logic [CW-1:0] cnt;
  dm_req_t req_in, req_q, cur;
  logic [NUM_LANES-1:0][LANE_W-1:0] mmio_q;

  assign req_in = '{we: req_we, size: req_size, sgn: req_signed,
                    addr: req_addr, wdata: req_wdata};
  // The request is captured on acceptance so completion does not depend on the core
  // keeping req_* stable.
  assign cur = (state == ST_IDLE) ? req_in : req_q;

  logic mis, bad_sz, in_mmio, in_rng, bad, accept, complete, cur_mmio;
  assign mis     = (req_in.size == SZ_HALF && req_in.addr[0]) ||
                   (req_in.size == SZ_WORD && req_in.addr[1:0] != 2'b00);
  assign bad_sz  = (req_in.size == 2'b11);
  assign in_mmio = (req_in.addr[31:2] == MMIO_ADDR[31:2]);
  assign in_rng  = ({2'b00, req_in.addr[31:2]} < 32'(DEPTH_WORDS));
  assign bad     = mis || bad_sz || (!in_mmio && !in_rng);

  assign accept   = (state == ST_IDLE) && req_valid && !bad;
  assign complete = (ZERO_WS && accept) || (state == ST_DONE);
  assign cur_mmio = (cur.addr[31:2] == MMIO_ADDR[31:2]);

  assign fault = (state == ST_IDLE) && req_valid && bad;
  assign stall = (state == ST_IDLE) ? (accept && !ZERO_WS) : (state == ST_WAIT);

  logic [NUM_LANES-1:0] be;
  logic [31:0] wsh, ram_rdata, src, sh, ld_val;
  logic ram_we;

  assign be     = lane_mask(cur.size, cur.addr[1:0]);
  assign wsh    = cur.wdata << {cur.addr[1:0], 3'b000};
  assign ram_we = complete && cur.we && !cur_mmio && !reset;

  dmem_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be),
    .waddr (cur.addr[AW+1:2]),
    .wdata (wsh),
    .raddr (cur.addr[AW+1:2]),
    .rdata (ram_rdata)
  );

  assign mmio_out = mmio_q;
  assign src = cur_mmio ? mmio_q : ram_rdata;
  assign sh  = src >> {cur.addr[1:0], 3'b000};

  always_comb begin
    case (cur.size)
      SZ_BYTE: ld_val = {{24{cur.sgn & sh[7]}},  sh[7:0]};
      SZ_HALF: ld_val = {{16{cur.sgn & sh[15]}}, sh[15:0]};
      default: ld_val = src;
    endcase
  end

  assign rdata = (complete && !cur.we) ? ld_val : 32'h0;

  // Accept counts as the first stalled cycle, so WAIT runs WAIT_STATES-1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      req_q  <= '0;
      mmio_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept && !ZERO_WS) begin
          req_q <= req_in;
          cnt   <= CW'(WAIT_STATES - 1);
          state <= (WAIT_STATES == 1) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
      if (complete && cur.we && cur_mmio) begin
        for (int l = 0; l < NUM_LANES; l++)
          if (be[l]) mmio_q[l] <= wsh[l*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: model-predicted responses queued at issue, checked by a monitor.
module tb_dmem_ctrl;
  import mem_pkg::*;

  localparam int          DEPTH = 64;
  localparam int          WS    = 1;
  localparam logic [31:0] MMIO  = 32'h0000_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_we, req_signed, stall, fault;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rdata, mmio_out;

  logic        r3_reset, r3_valid, r3_we, r3_signed, r3_stall, r3_fault;
  logic [1:0]  r3_size;
  logic [31:0] r3_addr, r3_wdata, r3_rdata, r3_mmio;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .MMIO_ADDR(MMIO)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .mmio_out(mmio_out));

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .MMIO_ADDR(MMIO)) u_dut3 (
    .clk(clk), .reset(r3_reset), .req_valid(r3_valid), .req_we(r3_we),
    .req_size(r3_size), .req_signed(r3_signed), .req_addr(r3_addr),
    .req_wdata(r3_wdata), .rdata(r3_rdata), .stall(r3_stall), .fault(r3_fault),
    .mmio_out(r3_mmio));

  int checks = 0, errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit          flt;
    bit          ld;
    logic [31:0] rd;
    logic [31:0] mmio;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] mmio_m, mon_mmio;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed memory arithmetic on whole words.
  task automatic model_op(input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int unsigned idx, nb, off;
    longint unsigned mask, word, v;
    bit mm;
    idx = a >> 2;
    mm  = ((a >> 2) == (MMIO >> 2));
    e.flt = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
            (!mm && idx >= DEPTH);
    e.ld = !we;
    e.rd = 32'h0;
    if (!e.flt) begin
      nb   = 1 << sz;
      mask = (64'd1 << (8 * nb)) - 1;
      off  = 8 * a[1:0];
      word = mm ? {32'h0, mmio_m} : {32'h0, mem_m[idx]};
      if (we) begin
        word = (word & ~(mask << off)) | (({32'h0, wd} & mask) << off);
        if (mm) mmio_m = word[31:0];
        else    mem_m[idx] = word[31:0];
      end else begin
        v = (word >> off) & mask;
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
        e.rd = v[31:0];
      end
    end
    e.mmio = mmio_m;
  endtask

  task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    exp_t e;
    int sc;
    bit done;
    rd = 32'h0;
    model_op(we, sz, sg, a, wd, e);
    sbq.push_back(e);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    sc = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (fault || !stall) begin
        done = 1'b1;
        rd = rdata;
      end else begin
        sc++;
        @(posedge clk); #1;
      end
    end
    chk("completion_timeout", 32'(done), 32'd1);
    chk("stall_cycles", 32'(sc), e.flt ? 32'd0 : 32'(WS));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic req3(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int sc);
    bit done;
    rd = 32'h0;
    r3_valid = 1'b1; r3_we = we; r3_size = SZ_WORD; r3_signed = 1'b0;
    r3_addr = a; r3_wdata = wd;
    sc = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (r3_fault || !r3_stall) begin
        done = 1'b1;
        rd = r3_rdata;
      end else begin
        sc++;
        @(posedge clk); #1;
      end
    end
    chk("ws3_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    r3_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per completion or fault cycle of the main DUT.
  exp_t me;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("mmio_out", mmio_out, mon_mmio);
      if (req_valid && (fault || !stall)) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow actual=response expected=none");
        end else begin
          me = sbq.pop_front();
          chk("fault", 32'(fault), 32'(me.flt));
          if (me.ld && !me.flt) chk("rdata", rdata, me.rd);
          if (me.flt) chk("fault_rdata", rdata, 32'h0);
          mon_mmio = me.mmio;
        end
      end else if (!req_valid) begin
        chk("idle_fault", 32'(fault), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic [1:0]  sz;
    int sc;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    r3_reset = 1'b1; r3_valid = 1'b0; r3_we = 1'b0; r3_size = 2'b00; r3_signed = 1'b0;
    r3_addr = 32'h0; r3_wdata = 32'h0;
    mmio_m = 32'h0; mon_mmio = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mmio", mmio_out, 32'h0);
    chk("rst3_mmio", r3_mmio, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; r3_reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) do_req(1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom, rd);

    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1234_5678, rd);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd);
    chk("ld_word_10", rd, 32'h1234_5678);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h80, rd);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, rd);
    chk("ld_sbyte_13", rd, 32'hFFFF_FF80);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, rd);
    chk("ld_ubyte_13", rd, 32'h0000_0080);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd);
    chk("ld_word_after_byte", rd, 32'h8034_5678);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h22, 32'hBEEF, rd);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, rd);
    chk("ld_shalf_22", rd, 32'hFFFF_BEEF);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd);
    chk("ld_word_20_hi", {16'h0, rd[31:16]}, 32'h0000_BEEF);

    do_req(1'b1, SZ_WORD, 1'b0, 32'h2,   32'hDEAD_DEAD, rd);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h1,   32'h0, rd);
    do_req(1'b0, 2'b11,   1'b0, 32'h0,   32'h0, rd);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h400, 32'h5555_5555, rd);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0,   32'h0, rd);

    do_req(1'b1, SZ_WORD, 1'b0, MMIO, 32'hA5A5_A5A5, rd);
    @(negedge clk);
    chk("mmio_after_store", mmio_out, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    do_req(1'b0, SZ_WORD, 1'b0, MMIO, 32'h0, rd);
    chk("ld_mmio", rd, 32'hA5A5_A5A5);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        7:       a = MMIO + 32'($urandom_range(0, 3));
        8, 9:    a = $urandom;
        default: a = 32'($urandom_range(0, DEPTH * 4 - 1));
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~(32'((1 << sz) - 1));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    req3(1'b1, 32'h40, 32'h1111_1111, rd, sc);
    chk("ws3_stall_cycles", 32'(sc), 32'd3);
    req3(1'b1, MMIO, 32'hCAFE_F00D, rd, sc);
    @(negedge clk);
    chk("ws3_mmio", r3_mmio, 32'hCAFE_F00D);
    @(posedge clk); #1;
    r3_valid = 1'b1; r3_we = 1'b1; r3_size = SZ_WORD; r3_addr = 32'h40; r3_wdata = 32'h2222_2222;
    @(negedge clk);
    chk("ws3_stall_1st", 32'(r3_stall), 32'd1);
    @(posedge clk); #1;
    r3_reset = 1'b1;
    @(negedge clk);
    chk("ws3_stall_2nd", 32'(r3_stall), 32'd1);
    @(posedge clk); #1;
    r3_reset = 1'b0; r3_valid = 1'b0;
    @(negedge clk);
    chk("ws3_post_rst_stall", 32'(r3_stall), 32'd0);
    chk("ws3_post_rst_mmio", r3_mmio, 32'h0);
    chk("ws3_post_rst_fault", 32'(r3_fault), 32'd0);
    chk("ws3_post_rst_rdata", r3_rdata, 32'h0);
    @(posedge clk); #1;
    req3(1'b0, 32'h40, 32'h0, rd, sc);
    chk("ws3_no_commit", rd, 32'h1111_1111);
    chk("ws3_load_stalls", 32'(sc), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
